// File: rtl/msi_pkg.sv
// Shared types and helpers for the MSI vector scheduler: FSM states, vector
// allocation mask and message payload construction.
package msi_pkg;

   typedef enum logic [0:0] {
      ST_IDLE,
      ST_ISSUE
   } msi_state_t;

   localparam int unsigned MSI_MAX_VECTORS = 32;
   localparam int unsigned MSI_IDX_W       = 5;

   // MME beyond the implemented vector count behaves as the largest allocation.
   function automatic logic [2:0] eff_mme(input logic [2:0] mme, input int unsigned vec_w);
      return (32'(mme) > vec_w) ? 3'(vec_w) : mme;
   endfunction

   function automatic logic [MSI_MAX_VECTORS-1:0] alloc_mask(input logic [2:0] mme_eff);
      logic [MSI_MAX_VECTORS-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MSI_MAX_VECTORS; i++) begin
         if (i < (32'd1 << mme_eff)) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [31:0] build_payload(
      input logic [15:0]          data,
      input logic [15:0]          ext_data,
      input logic                 ext_en,
      input logic [2:0]           mme_eff,
      input logic [MSI_IDX_W-1:0] vector
   );
      logic [15:0] fmask;
      fmask = 16'((32'd1 << mme_eff) - 32'd1);
      return {ext_en ? ext_data : 16'h0000,
              (data & ~fmask) | ({11'b0, vector} & fmask)};
   endfunction

endpackage

// File: rtl/msi_rr_arbiter.sv
// Combinational round-robin picker: first requesting index at or after the
// pointer, wrapping from NUM_VECTORS-1 back to 0.
module msi_rr_arbiter #(
   parameter int unsigned NUM_VECTORS = 32,
   parameter int unsigned VEC_W       = 5
) (
   input  logic [NUM_VECTORS-1:0] req,
   input  logic [VEC_W-1:0]       pointer,
   output logic [VEC_W-1:0]       grant,
   output logic                   any_grant
);

   always_comb begin
      logic [VEC_W-1:0] idx;
      idx       = '0;
      grant     = '0;
      any_grant = 1'b0;
      for (int unsigned k = 0; k < NUM_VECTORS; k++) begin
         idx = VEC_W'((32'(pointer) + k) % NUM_VECTORS);
         if (!any_grant && req[idx]) begin
            any_grant = 1'b1;
            grant     = idx;
         end
      end
   end

endmodule

// File: rtl/msi_vector_scheduler.sv
// MSI message sequencer: latches folded vector requests into pending bits,
// arbitrates round-robin among unmasked ones and issues one memory write at a time.
module msi_vector_scheduler
   import msi_pkg::*;
#(
   parameter int unsigned NUM_VECTORS = 32,
   parameter int unsigned VEC_W       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   msi_enable,
   input  logic [2:0]             multiple_message_enable,
   input  logic                   addr64_capable,
   input  logic                   per_vector_masking,
   input  logic                   extended_message_data_enable,
   input  logic [63:0]            message_address,
   input  logic [15:0]            message_data,
   input  logic [15:0]            extended_message_data,
   input  logic [NUM_VECTORS-1:0] mask_bits,
   input  logic [NUM_VECTORS-1:0] vec_req,
   output logic [NUM_VECTORS-1:0] pending_bits,
   output logic                   msg_valid,
   input  logic                   msg_ready,
   output logic [63:0]            msg_addr,
   output logic [31:0]            msg_payload,
   output logic [VEC_W-1:0]       msg_vector
);

   msi_state_t                 state;
   logic [VEC_W-1:0]           rr_ptr;
   logic [2:0]                 mme_eff;
   logic [MSI_MAX_VECTORS-1:0] amask_full;
   logic [NUM_VECTORS-1:0]     amask;
   logic [VEC_W-1:0]           idx_mask;
   logic [NUM_VECTORS-1:0]     folded;
   logic [NUM_VECTORS-1:0]     clear_vec;
   logic [NUM_VECTORS-1:0]     pending_next;
   logic [NUM_VECTORS-1:0]     eligible;
   logic [VEC_W-1:0]           grant;
   logic                       any_grant;
   logic                       handshake;
   logic [63:0]                addr_next;

   assign mme_eff    = eff_mme(multiple_message_enable, VEC_W);
   assign amask_full = alloc_mask(mme_eff);
   assign amask      = amask_full[NUM_VECTORS-1:0];
   assign idx_mask   = VEC_W'((32'd1 << mme_eff) - 32'd1);
   assign handshake  = msg_valid & msg_ready;

   always_comb begin
      folded = '0;
      for (int unsigned i = 0; i < NUM_VECTORS; i++) begin
         if (vec_req[i]) folded[VEC_W'(i) & idx_mask] = 1'b1;
      end
   end

   always_comb begin
      clear_vec = '0;
      if (handshake) clear_vec[msg_vector] = 1'b1;
   end

   // Set is applied after clear so a re-request in the handshake cycle survives;
   // the alloc mask drops bits left above a shrunken allocation.
   assign pending_next = ((pending_bits & ~clear_vec) | folded) & amask;

   assign eligible = pending_bits & ~(per_vector_masking ? mask_bits : '0) & amask;

   assign addr_next = {addr64_capable ? message_address[63:32] : 32'h0,
                       message_address[31:0] & 32'hFFFF_FFFC};

   msi_rr_arbiter #(
      .NUM_VECTORS (NUM_VECTORS),
      .VEC_W       (VEC_W)
   ) u_arb (
      .req       (eligible),
      .pointer   (rr_ptr),
      .grant     (grant),
      .any_grant (any_grant)
   );

   always_ff @(posedge clk) begin
      if (rst) pending_bits <= '0;
      else     pending_bits <= pending_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         msg_valid   <= 1'b0;
         msg_addr    <= '0;
         msg_payload <= '0;
         msg_vector  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (msi_enable && any_grant) begin
                  msg_addr    <= addr_next;
                  msg_payload <= build_payload(message_data, extended_message_data,
                                               extended_message_data_enable, mme_eff,
                                               MSI_IDX_W'(grant));
                  msg_vector  <= grant;
                  msg_valid   <= 1'b1;
                  state       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (msg_ready) begin
                  msg_valid <= 1'b0;
                  rr_ptr    <= (msg_vector == VEC_W'(NUM_VECTORS - 1)) ? '0 : msg_vector + 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_msi_vector_scheduler.sv
// Scoreboard bench for msi_vector_scheduler: expected messages are queued as
// requests are driven and checked in order at each handshake.
module tb_msi_vector_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        msi_enable = 1'b0;
   logic [2:0]  multiple_message_enable = 3'd0;
   logic        addr64_capable = 1'b0;
   logic        per_vector_masking = 1'b0;
   logic        extended_message_data_enable = 1'b0;
   logic [63:0] message_address = '0;
   logic [15:0] message_data = '0;
   logic [15:0] extended_message_data = '0;
   logic [31:0] mask_bits = '0;
   logic [31:0] vec_req = '0;
   logic [31:0] pending_bits;
   logic        msg_valid;
   logic        msg_ready = 1'b0;
   logic [63:0] msg_addr;
   logic [31:0] msg_payload;
   logic [4:0]  msg_vector;

   typedef struct {
      logic [63:0] addr;
      logic [31:0] payload;
      logic [4:0]  vector;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   msi_vector_scheduler #(.NUM_VECTORS(32)) dut (
      .clk                          (clk),
      .rst                          (rst),
      .msi_enable                   (msi_enable),
      .multiple_message_enable      (multiple_message_enable),
      .addr64_capable               (addr64_capable),
      .per_vector_masking           (per_vector_masking),
      .extended_message_data_enable (extended_message_data_enable),
      .message_address              (message_address),
      .message_data                 (message_data),
      .extended_message_data        (extended_message_data),
      .mask_bits                    (mask_bits),
      .vec_req                      (vec_req),
      .pending_bits                 (pending_bits),
      .msg_valid                    (msg_valid),
      .msg_ready                    (msg_ready),
      .msg_addr                     (msg_addr),
      .msg_payload                  (msg_payload),
      .msg_vector                   (msg_vector)
   );

   function automatic logic [31:0] exp_payload(input logic [15:0] d, input logic [15:0] x,
                                               input logic xe, input int mme, input int vec);
      logic [15:0] lo;
      logic [4:0]  v;
      lo = d;
      v  = 5'(vec);
      for (int b = 0; b < mme && b < 5; b++) lo[b] = v[b];
      return {xe ? x : 16'h0000, lo};
   endfunction

   function automatic logic [63:0] exp_addr(input logic [63:0] a, input logic cap);
      return {cap ? a[63:32] : 32'h0, a[31:2], 2'b00};
   endfunction

   function automatic exp_t mk(input int vec);
      exp_t e;
      e.addr    = exp_addr(message_address, addr64_capable);
      e.payload = exp_payload(message_data, extended_message_data,
                              extended_message_data_enable, int'(multiple_message_enable), vec);
      e.vector  = 5'(vec);
      return e;
   endfunction

   // Handshake monitor: every accepted message must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && msg_valid && msg_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_msg: got vector=%0d payload=%h, required no message", msg_vector, msg_payload);
         end else begin
            e = sb.pop_front();
            if (msg_addr !== e.addr || msg_payload !== e.payload || msg_vector !== e.vector) begin
               bad++;
               $display("FAIL msg_content: got addr=%h payload=%h vector=%0d, required addr=%h payload=%h vector=%0d",
                        msg_addr, msg_payload, msg_vector, e.addr, e.payload, e.vector);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      cyc(2);
      total++; if (pending_bits !== 32'h0) begin bad++; $display("FAIL reset_pending: got %h required 0", pending_bits); end
      total++; if (msg_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", msg_valid); end
      total++; if (msg_addr !== 64'h0) begin bad++; $display("FAIL reset_addr: got %h required 0", msg_addr); end
      total++; if (msg_payload !== 32'h0) begin bad++; $display("FAIL reset_payload: got %h required 0", msg_payload); end
      total++; if (msg_vector !== 5'd0) begin bad++; $display("FAIL reset_vector: got %0d required 0", msg_vector); end
      rst = 1'b0;
      cyc(1);
   endtask

   task automatic test_basic_issue;
      multiple_message_enable = 3'd0; msi_enable = 1'b1; message_data = 16'h4321;
      extended_message_data_enable = 1'b0; message_address = 64'h0000_0001_FEE0_0004;
      addr64_capable = 1'b0; msg_ready = 1'b1;
      sb.push_back(mk(0));
      vec_req = 32'h1;
      cyc(1);
      vec_req = '0;
      total++; if (pending_bits[0] !== 1'b1 || msg_valid !== 1'b0) begin bad++; $display("FAIL basic_pending_set: got pend0=%b valid=%b required 1/0", pending_bits[0], msg_valid); end
      cyc(1);
      total++; if (msg_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_latency: got %b required 1", msg_valid); end
      total++; if (msg_addr !== 64'h0000_0000_FEE0_0004 || msg_payload !== 32'h0000_4321) begin bad++; $display("FAIL basic_fields: got %h/%h required 00000000fee00004/00004321", msg_addr, msg_payload); end
      cyc(1);
      total++; if (pending_bits[0] !== 1'b0 || msg_valid !== 1'b0) begin bad++; $display("FAIL basic_cleared: got pend0=%b valid=%b required 0/0", pending_bits[0], msg_valid); end
      for (int c = 0; c < 20 && sb.size() != 0; c++) cyc(1);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL basic_drain: outstanding=%0d required 0", sb.size()); end
      cyc(2);
   endtask

   task automatic test_round_robin;
      multiple_message_enable = 3'd2; message_data = 16'h4320; extended_message_data = 16'hBEEF;
      extended_message_data_enable = 1'b1; addr64_capable = 1'b1;
      message_address = 64'h0000_0001_FEE0_0007;
      sb.push_back(mk(1)); sb.push_back(mk(2)); sb.push_back(mk(3));
      vec_req = 32'h0000_000E;
      cyc(1);
      vec_req = '0;
      for (int c = 0; c < 40 && sb.size() != 0; c++) cyc(1);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL rr_drain: outstanding=%0d required 0", sb.size()); end
      cyc(2);
      total++; if (pending_bits !== 32'h0) begin bad++; $display("FAIL rr_pending_clear: got %h required 0", pending_bits); end
      addr64_capable = 1'b0;
   endtask

   task automatic test_masking;
      int seen;
      int got;
      per_vector_masking = 1'b1; mask_bits = 32'h20; multiple_message_enable = 3'd3;
      extended_message_data_enable = 1'b0;
      vec_req = 32'h20;
      cyc(1);
      vec_req = '0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         cyc(1);
         if (msg_valid !== 1'b0) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL mask_no_issue: valid cycles=%0d required 0", seen); end
      total++; if (pending_bits[5] !== 1'b1) begin bad++; $display("FAIL mask_pending: got %b required 1", pending_bits[5]); end
      sb.push_back(mk(5));
      mask_bits = '0;
      got = 0;
      for (int c = 0; c < 2; c++) begin
         cyc(1);
         if (msg_valid === 1'b1) got = 1;
      end
      total++; if (got != 1) begin bad++; $display("FAIL unmask_issue: got valid=%0d required 1", got); end
      for (int c = 0; c < 20 && sb.size() != 0; c++) cyc(1);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL mask_drain: outstanding=%0d required 0", sb.size()); end
      cyc(2);
      per_vector_masking = 1'b0;
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   moved;
      msg_ready = 1'b0; multiple_message_enable = 3'd3;
      sb.push_back(mk(2)); sb.push_back(mk(2));
      e = sb[0];
      vec_req = 32'h4;
      cyc(1);
      vec_req = '0;
      for (int c = 0; c < 10 && msg_valid !== 1'b1; c++) cyc(1);
      total++; if (msg_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b required 1", msg_valid); end
      moved = 0;
      for (int c = 0; c < 10; c++) begin
         cyc(1);
         if (msg_valid !== 1'b1 || msg_addr !== e.addr || msg_payload !== e.payload || msg_vector !== e.vector) moved++;
      end
      total++; if (moved != 0) begin bad++; $display("FAIL bp_stable: unstable cycles=%0d required 0", moved); end
      msg_ready = 1'b1;
      vec_req = 32'h4;
      cyc(1);
      vec_req = '0;
      total++; if (pending_bits[2] !== 1'b1 || msg_valid !== 1'b0) begin bad++; $display("FAIL bp_rerequest: got pend2=%b valid=%b required 1/0", pending_bits[2], msg_valid); end
      for (int c = 0; c < 20 && sb.size() != 0; c++) cyc(1);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_drain: outstanding=%0d required 0", sb.size()); end
      cyc(2);
      total++; if (pending_bits !== 32'h0) begin bad++; $display("FAIL bp_pending_clear: got %h required 0", pending_bits); end
   endtask

   task automatic test_alias_disable;
      int seen;
      msi_enable = 1'b0; multiple_message_enable = 3'd3; msg_ready = 1'b1;
      vec_req = 32'h40;
      cyc(1);
      vec_req = '0;
      total++; if (pending_bits !== 32'h40) begin bad++; $display("FAIL disable_pending: got %h required 00000040", pending_bits); end
      multiple_message_enable = 3'd1;
      cyc(1);
      total++; if (pending_bits !== 32'h0) begin bad++; $display("FAIL shrink_clear: got %h required 0", pending_bits); end
      vec_req = 32'h48;
      cyc(1);
      vec_req = '0;
      total++; if (pending_bits !== 32'h3) begin bad++; $display("FAIL alias_fold: got %h required 00000003", pending_bits); end
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         cyc(1);
         if (msg_valid !== 1'b0) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL disable_no_issue: valid cycles=%0d required 0", seen); end
      sb.push_back(mk(0)); sb.push_back(mk(1));
      msi_enable = 1'b1;
      for (int c = 0; c < 30 && sb.size() != 0; c++) cyc(1);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL enable_drain: outstanding=%0d required 0", sb.size()); end
      cyc(2);
      total++; if (pending_bits !== 32'h0) begin bad++; $display("FAIL enable_pending_clear: got %h required 0", pending_bits); end
   endtask

   task automatic test_mid_reset;
      multiple_message_enable = 3'd3; msg_ready = 1'b0; msi_enable = 1'b1;
      vec_req = 32'h10;
      cyc(1);
      vec_req = '0;
      for (int c = 0; c < 10 && msg_valid !== 1'b1; c++) cyc(1);
      total++; if (msg_valid !== 1'b1 || msg_vector !== 5'd4) begin bad++; $display("FAIL midrst_issue: got valid=%b vector=%0d required 1/4", msg_valid, msg_vector); end
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      total++; if (msg_valid !== 1'b0 || pending_bits !== 32'h0 || msg_vector !== 5'd0) begin bad++; $display("FAIL midrst_state: got valid=%b pend=%h vector=%0d required 0/0/0", msg_valid, pending_bits, msg_vector); end
      sb.push_back(mk(1)); sb.push_back(mk(3));
      msg_ready = 1'b1;
      vec_req = 32'h0A;
      cyc(1);
      vec_req = '0;
      for (int c = 0; c < 30 && sb.size() != 0; c++) cyc(1);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL midrst_drain: outstanding=%0d required 0", sb.size()); end
      cyc(2);
   endtask

   initial begin
      test_reset();
      test_basic_issue();
      test_round_robin();
      test_masking();
      test_back_to_back();
      test_alias_disable();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/msi_vector_scheduler.md
Name: msi_vector_scheduler

Overview:
- Sequences MSI message generation for one function with up to NUM_VECTORS vectors.
- Latches vector interrupt requests into Pending bits and applies per-vector masking.
- Arbitrates round-robin among pending, unmasked vectors and issues one memory-write request at a time to the TLP transmit path over a valid/ready handshake.
- Builds the message payload from the Message Data register and, when enabled, the Extended Message Data register.

Parameters:
- NUM_VECTORS, 32, number of vectors the function supports; power of 2, range 1..32.
- VEC_W, $clog2(NUM_VECTORS) (minimum 1), width of the vector index.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- msi_enable  input  1  MSI Enable bit from Message Control.
- multiple_message_enable  input  3  MME field; allocated vector count = 2^MME.
- addr64_capable  input  1  64-bit Address Capable.
- per_vector_masking  input  1  Per-Vector Masking Capable.
- extended_message_data_enable  input  1  Extended Message Data Enable (already gated by capability upstream).
- message_address  input  64  Message Address (upper 32 bits from Upper Address register).
- message_data  input  16  Message Data register.
- extended_message_data  input  16  Extended Message Data register.
- mask_bits  input  NUM_VECTORS  Mask Bits register.
- vec_req  input  NUM_VECTORS  per-vector single-cycle interrupt request pulses.
- pending_bits  output  NUM_VECTORS  Pending Bits register, read-only to software.
- msg_valid  output  1  message request valid.
- msg_ready  input  1  transmit path accepts the message.
- msg_addr  output  64  DWORD-aligned write address.
- msg_payload  output  32  DW payload.
- msg_vector  output  VEC_W  vector being issued (debug/trace).

Behaviour:
- Reset (rst high at a clk edge):
  - pending_bits = 0, msg_valid = 0, msg_addr = 0, msg_payload = 0, msg_vector = 0.
  - Round-robin pointer = 0; FSM = IDLE.
  - An in-flight message is dropped with no ready required.
- Vector folding:
  - Let alloc = 2^min(MME, VEC_W).
  - vec_req[i] sets pending_bits[i & (alloc-1)].
  - Pending bits at indices >= alloc never set.
- Pending set: a request pulse at cycle N makes its pending bit visible at N+1.
- Eligibility: eligible[i] = pending_bits[i] & ~(per_vector_masking & mask_bits[i]) & (i < alloc).
  - If per_vector_masking = 0, mask_bits is ignored.
- FSM IDLE:
  - Condition: msi_enable = 1 and any eligible bit set.
  - Action: select the first eligible index at or after the RR pointer, wrapping at NUM_VECTORS-1 to 0.
  - Register addr, payload and vector; go to ISSUE. msg_valid rises the cycle after entry into IDLE with eligibility.
- FSM ISSUE:
  - msg_valid = 1; msg_addr, msg_payload and msg_vector are held stable until the handshake.
  - On msg_valid & msg_ready:
    - Clear the granted pending bit.
    - RR pointer = granted + 1 (mod NUM_VECTORS).
    - Return to IDLE.
  - Minimum one idle cycle between messages; maximum throughput is 1 message per 2 cycles.
- Address: msg_addr = message_address with bits [1:0] forced to 0.
  - If addr64_capable = 0, bits [63:32] are forced to 0.
- Payload:
  - Low 16 bits = message_data with bits [MME-1:0] replaced by the vector index (none replaced when MME = 0).
  - High 16 bits = extended_message_data if extended_message_data_enable, else 16'h0000.
- Simultaneous events:
  - A vec_req for the granted vector in the handshake cycle: set wins, and the pending bit stays 1.
  - A mask set or msi_enable deasserted while in ISSUE: the message is not withdrawn and completes on msg_ready.
  - msi_enable = 0 in IDLE: no new issue; pending bits keep accumulating.
  - An MME change shrinking alloc clears pending bits at indices >= the new alloc on the next cycle.
- The vector-unmask edge triggers no special action; a pending, now unmasked vector becomes eligible on the following cycle.

Decomposition:
- Shared package msi_pkg:
  - FSM state typedef (IDLE, ISSUE).
  - MSI_MAX_VECTORS = 32.
  - A function computing the alloc mask from MME.
  - A function building the payload.
- One sub-module, msi_rr_arbiter: NUM_VECTORS-wide round-robin priority picker with inputs req/pointer and outputs grant index and any_grant. It is combinational and instantiated once.
- Pending register, FSM and output registers stay in the top module.

Test Plan:
- Basic issue:
  - Stimulus: MME=0, msi_enable=1, message_data=16'h4321, ext enable=0, addr=64'h0000_0001_FEE0_0004, addr64_capable=0, vec_req[0] pulse, msg_ready tied 1.
  - Required: msg_valid 2 cycles after the pulse; msg_addr=64'hFEE0_0004; msg_payload=32'h0000_4321; pending_bits[0] back to 0.
- Multi-vector round robin:
  - Stimulus: MME=2, message_data=16'h4320, extended_message_data=16'hBEEF, ext enable=1; vec_req[3], [1] and [2] pulsed in the same cycle.
  - Required: issue order 1, 2, 3; payloads 32'hBEEF_4321, 32'hBEEF_4322, 32'hBEEF_4323.
- Masking:
  - Stimulus: per_vector_masking=1, mask_bits[5]=1, MME=3, vec_req[5] pulse.
  - Required: pending_bits[5]=1 and no msg_valid for 20 cycles; then clear mask_bits[5], and msg_valid follows within 2 cycles with payload low bits = 5.
- Backpressure plus re-request:
  - Stimulus: hold msg_ready=0 for 10 cycles while in ISSUE; pulse vec_req for the same vector during the handshake cycle.
  - Required: outputs stable for all 10 cycles; after the handshake pending stays 1, and a second message is issued.
- Aliasing and disable:
  - Stimulus: MME=1, vec_req[6].
  - Required: pending_bits[0] sets (6 & 1 = 0).
  - Stimulus: with msi_enable=0, pulse requests.
  - Required: no msg_valid while pending accumulates; re-enable, and the messages issue.
- Mid-operation reset:
  - Stimulus: assert rst for 1 cycle during ISSUE with msg_ready=0.
  - Required: next cycle msg_valid=0, pending_bits=0, RR pointer=0.
